// File: rtl/exception_sequencer.sv
// ----------------------------------------------------------------------------
// exception_sequencer
//
// Sequences the pipeline's response to an exception raised by the exception
// detection logic. It captures the faulting PC and cause, then flushes the
// affected pipeline registers for a fixed number of cycles. After that it
// redirects fetch to the handler. When the handler asks to return, fetch
// resumes at the instruction that follows the faulting one.
//
// Every output is registered. Each one is decoded from the state the machine
// is about to enter, so it is valid for the whole cycle spent in that state.
//
// Ports
//   clk            in   clock, all state on the rising edge
//   rst            in   asynchronous active-high reset
//   ExceptionCause in   0 none, 1 bad opcode, 2 bad funct, 3 bad reg,
//                       4 ALU overflow, 5-7 reserved
//   ExceptionPC    in   PC of the faulting instruction
//   Eret           in   handler requests return
//   ClearCause     out  one-cycle pulse telling the exception unit to clear
//   FlushIFID      out  flush IF/ID register
//   FlushIDEX      out  flush ID/EX register
//   FlushEXMEM     out  flush EX/MEM register
//   StallPC        out  hold the PC
//   PCLoad         out  load PCTarget into the PC this cycle
//   PCTarget       out  redirect address, 0 whenever PCLoad is low
//   EPC            out  latched exception PC
//   CauseReg       out  latched cause
//   InHandler      out  handler executing
//   DoubleFault    out  sticky, an exception arrived while busy
//   ExcCount       out  accepted exceptions, saturating at 255
// ----------------------------------------------------------------------------
module exception_sequencer #(
   parameter int                     PC_WIDTH     = 6,
   parameter logic [PC_WIDTH-1:0]    HANDLER_ADDR = 6'd48,
   parameter int                     FLUSH_CYCLES = 2,
   parameter int                     PC_STEP      = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [2:0]          ExceptionCause,
   input  logic [PC_WIDTH-1:0] ExceptionPC,
   input  logic                Eret,
   output logic                ClearCause,
   output logic                FlushIFID,
   output logic                FlushIDEX,
   output logic                FlushEXMEM,
   output logic                StallPC,
   output logic                PCLoad,
   output logic [PC_WIDTH-1:0] PCTarget,
   output logic [PC_WIDTH-1:0] EPC,
   output logic [2:0]          CauseReg,
   output logic                InHandler,
   output logic                DoubleFault,
   output logic [7:0]          ExcCount
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FLUSH,
      ST_REDIRECT,
      ST_HANDLER,
      ST_RETURN
   } state_t;

   localparam logic [3:0]          FLUSH_LOAD = 4'(FLUSH_CYCLES);
   localparam logic [PC_WIDTH-1:0] STEP       = PC_WIDTH'(PC_STEP);
   localparam logic [2:0]          CAUSE_OVF  = 3'd4;

   state_t              state_q, state_d;
   logic [3:0]          flushCnt_q, flushCnt_d;
   logic [PC_WIDTH-1:0] epc_q, epc_d;
   logic [2:0]          cause_q, cause_d;
   logic [7:0]          excCount_q, excCount_d;
   logic                doubleFault_q, doubleFault_d;

   logic                clearCause_q, clearCause_d;
   logic                flushIFID_q, flushIFID_d;
   logic                flushIDEX_q, flushIDEX_d;
   logic                flushEXMEM_q, flushEXMEM_d;
   logic                stallPC_q, stallPC_d;
   logic                pcLoad_q, pcLoad_d;
   logic [PC_WIDTH-1:0] pcTarget_q, pcTarget_d;
   logic                inHandler_q, inHandler_d;

   logic                validCause;
   logic                anyCause;

   // Only causes 1-4 start an exception sequence. The reserved codes 5-7
   // are ignored in IDLE. Any nonzero code that arrives while the machine
   // is busy still counts as a double fault.
   assign validCause = (ExceptionCause >= 3'd1) && (ExceptionCause <= 3'd4);
   assign anyCause   = (ExceptionCause != 3'd0);

   // Next-state logic. A new exception is only taken from IDLE. In every
   // other state a nonzero cause sets the sticky DoubleFault flag and
   // pulses ClearCause, so the exception unit is never left waiting. EPC,
   // CauseReg and ExcCount are left untouched in that case, so the handler
   // that is already running still returns to the original fault site.
   always_comb begin
      state_d       = state_q;
      flushCnt_d    = flushCnt_q;
      epc_d         = epc_q;
      cause_d       = cause_q;
      excCount_d    = excCount_q;
      doubleFault_d = doubleFault_q;
      clearCause_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (validCause) begin
               epc_d        = ExceptionPC;
               cause_d      = ExceptionCause;
               excCount_d   = (excCount_q == 8'hFF) ? excCount_q : excCount_q + 8'd1;
               clearCause_d = 1'b1;
               flushCnt_d   = FLUSH_LOAD;
               state_d      = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            // The counter is loaded with FLUSH_CYCLES on entry. Leaving when
            // it reads 1 gives exactly FLUSH_CYCLES cycles in this state.
            if (flushCnt_q <= 4'd1) begin
               flushCnt_d = 4'd0;
               state_d    = ST_REDIRECT;
            end else begin
               flushCnt_d = flushCnt_q - 4'd1;
            end
         end
         ST_REDIRECT: begin
            state_d = ST_HANDLER;
         end
         ST_HANDLER: begin
            if (Eret) begin
               state_d = ST_RETURN;
            end
         end
         ST_RETURN: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if ((state_q != ST_IDLE) && anyCause) begin
         doubleFault_d = 1'b1;
         clearCause_d  = 1'b1;
      end
   end

   // Output decode. It is driven from the state being entered, so the
   // registered copies line up with the state they describe. The EX/MEM
   // register is only flushed for an ALU overflow: in that case the
   // faulting instruction has already reached EX.
   always_comb begin
      flushIFID_d  = 1'b0;
      flushIDEX_d  = 1'b0;
      flushEXMEM_d = 1'b0;
      stallPC_d    = 1'b0;
      pcLoad_d     = 1'b0;
      pcTarget_d   = '0;
      inHandler_d  = 1'b0;

      case (state_d)
         ST_FLUSH: begin
            stallPC_d    = 1'b1;
            flushIFID_d  = 1'b1;
            flushIDEX_d  = 1'b1;
            flushEXMEM_d = (cause_d == CAUSE_OVF);
         end
         ST_REDIRECT: begin
            pcLoad_d    = 1'b1;
            pcTarget_d  = HANDLER_ADDR;
            flushIFID_d = 1'b1;
         end
         ST_HANDLER: begin
            inHandler_d = 1'b1;
         end
         ST_RETURN: begin
            // Wraps modulo 2^PC_WIDTH by truncation.
            pcLoad_d    = 1'b1;
            pcTarget_d  = epc_d + STEP;
            flushIFID_d = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // State and registered outputs. Reset is asynchronous, so a reset
   // that arrives mid-sequence drops flush, stall and load straight away,
   // without waiting for the next clock edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         flushCnt_q    <= 4'd0;
         epc_q         <= '0;
         cause_q       <= 3'd0;
         excCount_q    <= 8'd0;
         doubleFault_q <= 1'b0;
         clearCause_q  <= 1'b0;
         flushIFID_q   <= 1'b0;
         flushIDEX_q   <= 1'b0;
         flushEXMEM_q  <= 1'b0;
         stallPC_q     <= 1'b0;
         pcLoad_q      <= 1'b0;
         pcTarget_q    <= '0;
         inHandler_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         flushCnt_q    <= flushCnt_d;
         epc_q         <= epc_d;
         cause_q       <= cause_d;
         excCount_q    <= excCount_d;
         doubleFault_q <= doubleFault_d;
         clearCause_q  <= clearCause_d;
         flushIFID_q   <= flushIFID_d;
         flushIDEX_q   <= flushIDEX_d;
         flushEXMEM_q  <= flushEXMEM_d;
         stallPC_q     <= stallPC_d;
         pcLoad_q      <= pcLoad_d;
         pcTarget_q    <= pcTarget_d;
         inHandler_q   <= inHandler_d;
      end
   end

   assign ClearCause  = clearCause_q;
   assign FlushIFID   = flushIFID_q;
   assign FlushIDEX   = flushIDEX_q;
   assign FlushEXMEM  = flushEXMEM_q;
   assign StallPC     = stallPC_q;
   assign PCLoad      = pcLoad_q;
   assign PCTarget    = pcTarget_q;
   assign EPC         = epc_q;
   assign CauseReg    = cause_q;
   assign InHandler   = inHandler_q;
   assign DoubleFault = doubleFault_q;
   assign ExcCount    = excCount_q;

endmodule

// File: tb/tb_exception_sequencer.sv
// ----------------------------------------------------------------------------
// tb_exception_sequencer
//
// Self-checking bench for exception_sequencer. Inputs are applied one cycle
// at a time from a table. Each row's expected outputs are pushed to a
// scoreboard queue when the row is driven. They are popped and compared on
// the following falling edge. Hand-written sequences cover reset during
// FLUSH and ExcCount saturation.
// ----------------------------------------------------------------------------
module tb_exception_sequencer;

   // Flag bit order: [6] ClearCause [5] FlushIFID [4] FlushIDEX
   // [3] FlushEXMEM [2] StallPC [1] PCLoad [0] InHandler
   localparam logic [6:0] F_IDLE = 7'b0000000;
   localparam logic [6:0] F_CLR  = 7'b1000000;
   localparam logic [6:0] F_FL   = 7'b0110100;
   localparam logic [6:0] F_FL4  = 7'b0111100;
   localparam logic [6:0] F_LOAD = 7'b0100010;
   localparam logic [6:0] F_HND  = 7'b0000001;

   typedef struct {
      logic [6:0] flags;
      logic [5:0] tgt;
      logic [5:0] epc;
      logic [2:0] creg;
      logic       df;
      logic [7:0] cnt;
   } exp_t;

   typedef struct {
      logic [2:0] cause;
      logic [5:0] pc;
      logic       eret;
      exp_t       e;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [2:0] ExceptionCause = 3'd0;
   logic [5:0] ExceptionPC = 6'd0;
   logic       Eret = 1'b0;
   logic       ClearCause, FlushIFID, FlushIDEX, FlushEXMEM, StallPC, PCLoad;
   logic       InHandler, DoubleFault;
   logic [5:0] PCTarget, EPC;
   logic [2:0] CauseReg;
   logic [7:0] ExcCount;

   int   checks = 0;
   int   failures = 0;
   exp_t expQ[$];
   vec_t tbl[$];

   exception_sequencer dut (
      .clk(clk), .rst(rst),
      .ExceptionCause(ExceptionCause), .ExceptionPC(ExceptionPC), .Eret(Eret),
      .ClearCause(ClearCause), .FlushIFID(FlushIFID), .FlushIDEX(FlushIDEX),
      .FlushEXMEM(FlushEXMEM), .StallPC(StallPC), .PCLoad(PCLoad),
      .PCTarget(PCTarget), .EPC(EPC), .CauseReg(CauseReg),
      .InHandler(InHandler), .DoubleFault(DoubleFault), .ExcCount(ExcCount)
   );

   always #5 clk = ~clk;

   function automatic vec_t mkv(input logic [2:0] cause, input logic [5:0] pc,
                                input logic eret, input logic [6:0] flags,
                                input logic [5:0] tgt, input logic [5:0] epc,
                                input logic [2:0] creg, input logic df,
                                input logic [7:0] cnt);
      vec_t v;
      v.cause = cause; v.pc = pc; v.eret = eret;
      v.e.flags = flags; v.e.tgt = tgt; v.e.epc = epc;
      v.e.creg = creg; v.e.df = df; v.e.cnt = cnt;
      return v;
   endfunction

   task automatic cmp(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one row's inputs just after a falling edge and queue its
   // expected outputs.
   task automatic applyStimulus(input vec_t v);
      ExceptionCause = v.cause;
      ExceptionPC    = v.pc;
      Eret           = v.eret;
      expQ.push_back(v.e);
      @(posedge clk);
      @(negedge clk);
   endtask

   // Pop the oldest expectation and compare it against the live outputs.
   task automatic checkOutput(input string tag);
      exp_t e;
      if (expQ.size() == 0) begin
         cmp({tag, " scoreboard empty"}, 1, 0);
         return;
      end
      e = expQ.pop_front();
      cmp({tag, " ClearCause"}, ClearCause, e.flags[6]);
      cmp({tag, " FlushIFID"},  FlushIFID,  e.flags[5]);
      cmp({tag, " FlushIDEX"},  FlushIDEX,  e.flags[4]);
      cmp({tag, " FlushEXMEM"}, FlushEXMEM, e.flags[3]);
      cmp({tag, " StallPC"},    StallPC,    e.flags[2]);
      cmp({tag, " PCLoad"},     PCLoad,     e.flags[1]);
      cmp({tag, " InHandler"},  InHandler,  e.flags[0]);
      cmp({tag, " PCTarget"},   PCTarget,   e.tgt);
      cmp({tag, " EPC"},        EPC,        e.epc);
      cmp({tag, " CauseReg"},   CauseReg,   e.creg);
      cmp({tag, " DoubleFault"}, DoubleFault, e.df);
      cmp({tag, " ExcCount"},   ExcCount,   e.cnt);
   endtask

   task automatic run(input string tag, input vec_t v);
      applyStimulus(v);
      checkOutput(tag);
   endtask

   task automatic checkAllZero(input string tag);
      cmp({tag, " ClearCause"}, ClearCause, 0);
      cmp({tag, " FlushIFID"},  FlushIFID,  0);
      cmp({tag, " FlushIDEX"},  FlushIDEX,  0);
      cmp({tag, " FlushEXMEM"}, FlushEXMEM, 0);
      cmp({tag, " StallPC"},    StallPC,    0);
      cmp({tag, " PCLoad"},     PCLoad,     0);
      cmp({tag, " PCTarget"},   PCTarget,   0);
      cmp({tag, " EPC"},        EPC,        0);
      cmp({tag, " CauseReg"},   CauseReg,   0);
      cmp({tag, " InHandler"},  InHandler,  0);
      cmp({tag, " DoubleFault"}, DoubleFault, 0);
      cmp({tag, " ExcCount"},   ExcCount,   0);
   endtask

   initial begin
      // cause 1 at PC 10: two FLUSH cycles, redirect to 48, then return to 11
      tbl.push_back(mkv(1, 10, 0, F_CLR | F_FL, 0,  10, 1, 0, 1));
      tbl.push_back(mkv(0, 0,  0, F_FL,         0,  10, 1, 0, 1));
      tbl.push_back(mkv(0, 0,  0, F_LOAD,       48, 10, 1, 0, 1));
      tbl.push_back(mkv(0, 0,  0, F_HND,        0,  10, 1, 0, 1));
      tbl.push_back(mkv(0, 0,  1, F_LOAD,       11, 10, 1, 0, 1));
      tbl.push_back(mkv(0, 0,  1, F_IDLE,       0,  10, 1, 0, 1));
      tbl.push_back(mkv(0, 0,  1, F_IDLE,       0,  10, 1, 0, 1));
      // cause 4 at PC 20: EX/MEM flushed too, five handler cycles, return 21
      tbl.push_back(mkv(4, 20, 0, F_CLR | F_FL4, 0,  20, 4, 0, 2));
      tbl.push_back(mkv(0, 0,  0, F_FL4,         0,  20, 4, 0, 2));
      tbl.push_back(mkv(0, 0,  0, F_LOAD,        48, 20, 4, 0, 2));
      for (int i = 0; i < 5; i++)
         tbl.push_back(mkv(0, 0, 0, F_HND, 0, 20, 4, 0, 2));
      tbl.push_back(mkv(0, 0,  1, F_LOAD,        21, 20, 4, 0, 2));
      tbl.push_back(mkv(0, 0,  0, F_IDLE,        0,  20, 4, 0, 2));
      // reserved cause in IDLE is ignored
      tbl.push_back(mkv(6, 40, 0, F_IDLE,        0,  20, 4, 0, 2));
      // cause 3 at PC 63, double fault in HANDLER, return wraps to 0
      tbl.push_back(mkv(3, 63, 0, F_CLR | F_FL,  0,  63, 3, 0, 3));
      tbl.push_back(mkv(0, 0,  0, F_FL,          0,  63, 3, 0, 3));
      tbl.push_back(mkv(0, 0,  0, F_LOAD,        48, 63, 3, 0, 3));
      tbl.push_back(mkv(0, 0,  0, F_HND,         0,  63, 3, 0, 3));
      tbl.push_back(mkv(2, 5,  0, F_CLR | F_HND, 0,  63, 3, 1, 3));
      tbl.push_back(mkv(0, 0,  1, F_LOAD,        0,  63, 3, 1, 3));
      tbl.push_back(mkv(0, 0,  0, F_IDLE,        0,  63, 3, 1, 3));
      // cause and Eret together in HANDLER: return taken, cause pulsed away
      tbl.push_back(mkv(1, 30, 0, F_CLR | F_FL,   0,  30, 1, 1, 4));
      tbl.push_back(mkv(0, 0,  0, F_FL,           0,  30, 1, 1, 4));
      tbl.push_back(mkv(0, 0,  0, F_LOAD,         48, 30, 1, 1, 4));
      tbl.push_back(mkv(0, 0,  0, F_HND,          0,  30, 1, 1, 4));
      tbl.push_back(mkv(4, 0,  1, F_CLR | F_LOAD, 31, 30, 1, 1, 4));
      tbl.push_back(mkv(0, 0,  0, F_IDLE,         0,  30, 1, 1, 4));

      rst = 1'b1;
      #2;
      checkAllZero("reset");
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < tbl.size(); i++)
         run($sformatf("row%0d", i), tbl[i]);

      // Reset in the second FLUSH cycle clears everything between edges.
      run("rstA", mkv(1, 12, 0, F_CLR | F_FL, 0, 12, 1, 1, 5));
      run("rstB", mkv(0, 0,  0, F_FL,         0, 12, 1, 1, 5));
      rst = 1'b1;
      #1;
      checkAllZero("midflush");
      #1;
      rst = 1'b0;
      run("after0", mkv(3, 7, 0, F_CLR | F_FL, 0, 7, 3, 0, 1));
      run("after1", mkv(0, 0, 0, F_FL,         0, 7, 3, 0, 1));
      run("after2", mkv(0, 0, 0, F_LOAD,       48, 7, 3, 0, 1));
      run("after3", mkv(0, 0, 0, F_HND,        0, 7, 3, 0, 1));
      run("after4", mkv(0, 0, 1, F_LOAD,       8, 7, 3, 0, 1));
      run("after5", mkv(0, 0, 0, F_IDLE,       0, 7, 3, 0, 1));

      // 256 accepted exceptions saturate ExcCount at 255.
      rst = 1'b1;
      #1;
      rst = 1'b0;
      for (int i = 0; i < 256; i++) begin
         logic [5:0] pc;
         logic [7:0] cnt;
         pc  = 6'(i);
         cnt = (i >= 254) ? 8'd255 : 8'(i + 1);
         run("sat0", mkv(1, pc, 0, F_CLR | F_FL, 0, pc, 1, 0, cnt));
         run("sat1", mkv(0, 0,  0, F_FL,         0, pc, 1, 0, cnt));
         run("sat2", mkv(0, 0,  0, F_LOAD,       48, pc, 1, 0, cnt));
         run("sat3", mkv(0, 0,  0, F_HND,        0, pc, 1, 0, cnt));
         run("sat4", mkv(0, 0,  1, F_LOAD,       pc + 6'd1, pc, 1, 0, cnt));
         run("sat5", mkv(0, 0,  0, F_IDLE,       0, pc, 1, 0, cnt));
      end

      if (expQ.size() != 0)
         cmp("scoreboard drained", expQ.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
